// File: rtl/fpu_result_collector.sv
// fpu_result_collector: result FIFO with sticky flags, irq and optional event counters (FPU_EVENT_COUNTERS_EN)
module fpu_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_z,
  input  logic [7:0]                 in_status,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_z,
  output logic [7:0]                 out_status,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 sticky,
  input  logic                       sticky_clr,
  output logic                       bad_status,
  input  logic [7:0]                 irq_mask,
  output logic                       irq,
  input  logic [2:0]                 cnt_sel,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           cnt_value
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [31:0] mem_z_q [DEPTH];
  logic [7:0] mem_s_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  logic [7:0] sticky_q, sticky_d;
  logic bad_q, bad_d, push, pop, bad_in;
  assign in_ready = lvl_q != FULL_LVL && !rst;
  assign out_valid = lvl_q != '0;
  assign out_z = mem_z_q[rd_q];
  assign out_status = mem_s_q[rd_q];
  assign fifo_level = lvl_q;
  assign sticky = sticky_q;
  assign bad_status = bad_q;
  assign irq = |(sticky_q & ~irq_mask) | bad_q;
  // handshakes, pointer/level advance and sticky flags; a new event wins over a same-cycle clear
  always_comb begin
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    bad_in = (in_status[5] & in_status[4]) | (in_status[5] & in_status[3]) | (in_status[4] & in_status[3]) | (in_status[2] & in_status[1]);
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    lvl_d = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    sticky_d = (sticky_clr ? 8'h00 : sticky_q) | (push ? in_status : 8'h00);
    bad_d = (!sticky_clr && bad_q) || (push && bad_in);
  end
  // control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      sticky_q <= '0;
      bad_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      sticky_q <= sticky_d;
      bad_q <= bad_d;
    end
  end
  // payload storage needs no reset; validity is tracked by the level
  always_ff @(posedge clk) begin
    if (push) begin
      mem_z_q[wr_q] <= in_z;
      mem_s_q[wr_q] <= in_status;
    end
  end
`ifdef FPU_EVENT_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  assign cnt_value = cnt_q[cnt_sel];
  // per-flag saturating counters; a clear with a push restarts at the pushed bit
  always_comb begin
    for (int i = 0; i < 8; i++)
      cnt_d[i] = cnt_clr ? CNT_W'(push && in_status[i]) : cnt_q[i] + CNT_W'(push && in_status[i] && cnt_q[i] != '1);
  end
  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, cnt_clr};
  assign cnt_value = '0;
`endif
endmodule

// File: tb/tb_fpu_result_collector.sv
// tb_fpu_result_collector: random and directed checks against a queue-based reference model
module tb_fpu_result_collector;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, sticky_clr = 0, cnt_clr = 0;
  logic [31:0] in_z = 0;
  logic [7:0] in_status = 0, irq_mask = 0;
  logic [2:0] cnt_sel = 0;
  logic in_ready, out_valid, bad_status, irq;
  logic [31:0] out_z;
  logic [7:0] out_status, sticky;
  logic [2:0] fifo_level;
  logic [CNT_W-1:0] cnt_value;
  logic [39:0] q[$];
  logic [7:0] m_sticky = 0;
  logic m_bad = 0;
  int m_cnt[8];
  int n_checks = 0, n_fail = 0;

  fpu_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_status(in_status), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_status(out_status), .fifo_level(fifo_level), .sticky(sticky), .sticky_clr(sticky_clr),
    .bad_status(bad_status), .irq_mask(irq_mask), .irq(irq), .cnt_sel(cnt_sel),
    .cnt_clr(cnt_clr), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef FPU_EVENT_COUNTERS_EN
    return m_cnt[cnt_sel];
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs();
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_z", out_z, q[0][31:0]);
      chk("out_status", 32'(out_status), 32'(q[0][39:32]));
    end
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("bad_status", 32'(bad_status), 32'(m_bad));
    chk("irq", 32'(irq), 32'((|(m_sticky & ~irq_mask)) | m_bad));
    chk("cnt_value", 32'(cnt_value), 32'(exp_cnt()));
  endtask

  task automatic step(input logic v, input logic [31:0] z, input logic [7:0] s, input logic ordy,
                      input logic sc = 0, input logic cc = 0, input logic r = 0);
    bit push, pop;
    rst = r; in_valid = v; in_z = z; in_status = s; out_ready = ordy; sticky_clr = sc; cnt_clr = cc;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!r && q.size() < DEPTH));
    push = v && !r && q.size() < DEPTH;
    pop = !r && q.size() > 0 && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_sticky = 0;
      m_bad = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({s, z});
      if (sc) begin
        m_sticky = 0;
        m_bad = 0;
      end
      if (push) begin
        m_sticky |= s;
        if ($countones(s[5:3]) > 1 || (s[2] && s[1])) m_bad = 1;
        foreach (m_cnt[i]) m_cnt[i] = cc ? int'(s[i]) : (s[i] ? (m_cnt[i] + 1 > MAXC ? MAXC : m_cnt[i] + 1) : m_cnt[i]);
      end else if (cc) foreach (m_cnt[i]) m_cnt[i] = 0;
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [7:0] rnd_status();
    return 8'(1 << $urandom_range(0, 7)) | ($urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00);
  endfunction

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_irq", 32'(irq), 0);
    step(0, 0, 0, 0);
    step(1, 32'h3F800000, 8'h01, 0);
    chk("tp_out_z", out_z, 32'h3F800000);
    chk("tp_sticky", 32'(sticky), 32'h01);
    chk("tp_irq", 32'(irq), 1);
    irq_mask = 8'h01;
    #1;
    chk("tp_irq_masked", 32'(irq), 0);
    step(0, 0, 0, 1);
    repeat (3) begin
      for (int i = 0; i < 5; i++) step(1, $urandom, rnd_status(), 0);
      chk("full_level", 32'(fifo_level), 4);
      chk("full_ready", 32'(in_ready), 0);
      repeat (5) step(0, 0, 0, 1);
    end
    for (int i = 0; i < 4; i++) step(1, $urandom, rnd_status(), 0);
    step(1, $urandom, rnd_status(), 1);
    chk("full_pop_only", 32'(fifo_level), 3);
    step(1, $urandom, rnd_status(), 1);
    chk("push_pop_level", 32'(fifo_level), 3);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    irq_mask = 8'hFF;
    step(1, $urandom, 8'h30, 1);
    chk("bad_set", 32'(bad_status), 1);
    chk("bad_irq", 32'(irq), 1);
    step(1, $urandom, 8'h80, 1, 1);
    chk("clr_push_sticky", 32'(sticky), 32'h80);
    chk("clr_push_bad", 32'(bad_status), 0);
    cnt_sel = 3'd7;
    step(0, 0, 0, 1, 0, 1);
    repeat (20) step(1, $urandom, 8'h80, 1);
`ifdef FPU_EVENT_COUNTERS_EN
    chk("cnt_sat", 32'(cnt_value), 15);
`else
    chk("cnt_off", 32'(cnt_value), 0);
`endif
    step(1, $urandom, 8'h80, 1, 0, 1);
`ifdef FPU_EVENT_COUNTERS_EN
    chk("cnt_clr_push", 32'(cnt_value), 1);
`else
    chk("cnt_off_clr", 32'(cnt_value), 0);
`endif
    repeat (400) begin
      irq_mask = 8'($urandom);
      cnt_sel = 3'($urandom);
      step($urandom_range(0, 3) != 0, $urandom, rnd_status(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end
    repeat (5) step(0, 0, 0, 1);
    irq_mask = 8'h00;
    step(1, $urandom, 8'h04, 0);
    step(1, $urandom, 8'h02, 0);
    chk("pre_rst_level", 32'(fifo_level), 2);
    step(1, $urandom, 8'h01, 0, 0, 0, 1);
    chk("rst_mid_level", 32'(fifo_level), 0);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_sticky", 32'(sticky), 0);
    chk("rst_mid_irq", 32'(irq), 0);
    step(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_result_collector.md
# fpu_result_collector

Downstream stage of the FPU multiplier: accepts each result word `z` and its 8-bit status vector through a valid/ready handshake, buffers them in a small FIFO for the consumer, and keeps IEEE-style sticky exception flags. It raises a maskable interrupt and flags status vectors that violate flag exclusivity. Optional per-flag event counters support performance and debug readout.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; power of two, at least 2.
- `CNT_W`, 16 — width of each event counter.

Ports:
- `clk` in 1 — clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — upstream result valid.
- `in_ready` out 1 — collector can accept.
- `in_z` in 32 — single-precision result.
- `in_status` in 8 — {overflow, underflow, zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f}, bit 7 to bit 0.
- `out_valid` out 1 — FIFO head valid.
- `out_ready` in 1 — consumer accepts head.
- `out_z` out 32 — head result.
- `out_status` out 8 — head status.
- `fifo_level` out $clog2(DEPTH)+1 — occupied entries.
- `sticky` out 8 — accumulated status flags.
- `sticky_clr` in 1 — clear `sticky` and `bad_status`.
- `bad_status` out 1 — sticky protocol-violation flag.
- `irq_mask` in 8 — 1 masks the corresponding sticky bit from `irq`.
- `irq` out 1 — interrupt.
- `cnt_sel` in 3 — counter index (bit number of `in_status`).
- `cnt_clr` in 1 — clear all counters.
- `cnt_value` out CNT_W — selected counter.

## Operation
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- `in_ready = !full && !rst`. No bypass when full: a pop in the same cycle does not enable a push.
- Simultaneous push and pop while not full and not empty: level unchanged, both happen.
- FIFO is circular with wrapping read/write pointers. `out_z`/`out_status` show the head entry. When empty they hold their last value and are don't-care.
- Sticky update on push: `sticky <= (sticky_clr ? 0 : sticky) | in_status`. A new event wins over a same-cycle clear. `sticky_clr` without a push clears to 0.
- `bad_status` sets on any push whose status has more than one of {zero_f, inf_f, nan_f} set, or both tiny_f and huge_f set. Clear/set precedence is the same as for `sticky`.
- `irq = |(sticky & ~irq_mask) | bad_status`. It is combinational from the registered state, so it is visible the cycle after the causing push.
- Counters (when compiled in): on push, counter[i] increments for each set `in_status[i]` and saturates at 2^CNT_W−1.
  - `cnt_clr` with a push: counter[i] = `in_status[i]` (0 or 1).
  - `cnt_value = counter[cnt_sel]`, combinational.

## Timing
- Reset values: `out_valid` 0, `fifo_level` 0, `sticky` 0, `bad_status` 0, `irq` 0, all counters 0, pointers 0. `in_ready` is 0 while `rst` is high and 1 the first cycle after.
- Latency: a push into an empty FIFO gives `out_valid`=1 on the next cycle. Throughput is one transfer per cycle each side.
- `fifo_level`, `sticky`, `bad_status` and counters all update on the same edge as the push/pop that causes them.
- Reset mid-operation: all entries are discarded and any in-flight handshake in the reset cycle is ignored.
- `out_z`/`out_status` stay stable while `out_valid && !out_ready`.

## Configuration
- `FPU_EVENT_COUNTERS_EN` defined: the eight CNT_W counters, `cnt_sel`, `cnt_clr` and `cnt_value` are live as above.
- Not defined: no counter storage is built, `cnt_value` is tied to 0, and `cnt_sel`/`cnt_clr` are ignored. Ports remain present.

## Test plan
- Reset then single push of z=0x3F800000, status=0x01 with `out_ready`=0 → next cycle `out_valid`=1, `out_z`=0x3F800000, `fifo_level`=1, `sticky`=0x01, `irq`=1 with mask 0x00 and 0 with mask 0x01.
- Fill with DEPTH=4 pushes, `out_ready`=0 → `in_ready`=0, `fifo_level`=4. A fifth `in_valid` is not accepted. Drain with `out_ready`=1 → order preserved, empty after 4 cycles. Repeat 3 times to exercise pointer wrap.
- Full FIFO, `in_valid`=1, `out_ready`=1 for one cycle → pop only, level 3. Next cycle push and pop together → level stays 3.
- Push status=0x30 (zero_f|inf_f) → `bad_status`=1 and `irq`=1 regardless of mask. `sticky_clr` together with a push of 0x80 → `sticky`=0x80, `bad_status`=0.
- Counters compiled in, CNT_W=4: push status=0x80 twenty times → counter 7 reads 15 (saturated). `cnt_clr` with a push of 0x80 → reads 1. Without the macro, `cnt_value` reads 0 throughout.
- Assert `rst` while the FIFO holds 2 entries and `in_valid`=1 → next cycle `fifo_level`=0, `out_valid`=0, `sticky`=0, `irq`=0.
